// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_MIPS32 control slice.
//   - opcode constants for the instruction set
//   - reg_addr_t: 5-bit register address
//   - sb_entry_t: one scoreboard slot {valid, addr}
//   - hz_state_t: hazard controller sequencing states
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0a;
  localparam logic [5:0] OP_SUBI  = 6'h0b;
  localparam logic [5:0] OP_SLTI  = 6'h0c;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;
  localparam logic [5:0] OP_HLT   = 6'h3f;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_DONE    = 2'd2
  } hz_state_t;

endpackage

// File: rtl/mips32_scoreboard.sv
// Destination-register scoreboard for the in-flight producers.
// Entry 0 mirrors EX, entry 1 MEM, entry 2 WB. All entries shift by one
// every clock; entry 0 is loaded with the issuing instruction (or a bubble).
// Ports:
//   clk1, rst_n           clock, async active-low reset
//   load_valid, load_addr producer entering entry 0 this edge
//   id_valid, id_rs, id_use_rs, id_rt, id_use_rt   consumer in ID
//   hit                   ID consumer reads a pending nonzero destination
//   empty_next            no valid entry will remain after this edge
module mips32_scoreboard
  import mips32_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic      clk1,
  input  logic      rst_n,
  input  logic      load_valid,
  input  reg_addr_t load_addr,
  input  logic      id_valid,
  input  reg_addr_t id_rs,
  input  logic      id_use_rs,
  input  reg_addr_t id_rt,
  input  logic      id_use_rt,
  output logic      hit,
  output logic      empty_next
);

  sb_entry_t [SB_DEPTH-1:0] sb;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      sb[0] <= '{valid: load_valid, addr: load_addr};
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  // R0 is hard-wired zero, so a pending write to it never blocks a reader.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb[i].valid && (sb[i].addr != '0) &&
          ((id_use_rs && (id_rs == sb[i].addr)) ||
           (id_use_rt && (id_rt == sb[i].addr)))) begin
        hit = 1'b1;
      end
    end
    hit = hit & id_valid;
  end

  // The oldest entry falls off this edge, so only the younger ones and
  // the incoming load decide what remains.
  always_comb begin
    empty_next = !load_valid;
    for (int i = 0; i < SB_DEPTH - 1; i++) begin
      if (sb[i].valid) begin
        empty_next = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// RAW interlock, branch squash and halt sequencing for pipe_MIPS32.
// Ports:
//   clk1, rst_n            clock, async active-low reset
//   id_*                   decoded ID instruction (operands, dest, HLT)
//   ex_taken_branch        EX resolved a taken BEQZ/BNEQZ
//   stall                  hold PC and IF/ID, bubble into ID/EX
//   flush                  squash IF/ID
//   halted                 sticky after HLT issues
//   drained                halted and no producer left in flight
//   stall_cnt              saturating stall-cycle counter
//   dbg_state              RUN / HALTING / DONE sequencing state
// Handshake: the ID instruction is consumed on a rising edge where
// id_valid=1 and stall=0, flush=0, halted=0; otherwise ID must hold it
// (stall) or it is dropped (flush).
module mips32_hazard_ctrl
  import mips32_pkg::*;
#(
  parameter int SB_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_wr,
  input  logic             id_hlt,
  input  logic             ex_taken_branch,
  output logic             stall,
  output logic             flush,
  output logic             halted,
  output logic             drained,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  hz_state_t state;
  logic      hit;
  logic      sb_empty_next;
  logic      issue;
  logic      load_valid;

  // Flush outranks everything: the squashed instruction neither stalls,
  // issues, enters the scoreboard nor halts.
  assign flush      = ex_taken_branch;
  assign stall      = hit && !flush && !halted;
  assign issue      = id_valid && !hit && !flush && !halted;
  assign load_valid = issue && id_wr && (id_dest != '0);
  assign dbg_state  = state;

  mips32_scoreboard #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_addr  (id_dest),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_use_rs  (id_use_rs),
    .id_rt      (id_rt),
    .id_use_rt  (id_use_rt),
    .hit        (hit),
    .empty_next (sb_empty_next)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      halted  <= 1'b0;
      drained <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (issue && id_hlt) begin
            halted <= 1'b1;
            // Nothing left in flight (e.g. depth 1): skip straight to DONE.
            if (sb_empty_next) begin
              state   <= ST_DONE;
              drained <= 1'b1;
            end else begin
              state <= ST_HALTING;
            end
          end
        end
        ST_HALTING: begin
          if (sb_empty_next) begin
            state   <= ST_DONE;
            drained <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/mips32_hazard_ctrl.md
# mips32_hazard_ctrl

Register-dependence interlock and issue controller for the five-stage `pipe_MIPS32` pipeline. It detects read-after-write hazards and stalls ID, which replaces the hand-inserted dummy `OR R7,R7,R7` instructions in programs. It also squashes on taken branches and sequences `HLT` into a clean halt. It sits beside the ID stage, sees decoded operands from ID and branch resolution from EX, and drives the stall, flush and halt controls for IF/ID/EX.

## Interface
- `SB_DEPTH`, default 2: scoreboard entries, i.e. younger-producer distances checked; entry 0 = EX, 1 = MEM, 2 = WB. Legal range 1–3.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk1`  in  1  pipeline clock; single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  5 each  source register addresses.
- `id_use_rs`, `id_use_rt`  in  1 each  source actually read.
- `id_dest`  in  5  destination register: rd for RR-ALU, rt for RM-ALU and LW.
- `id_wr`  in  1  instruction writes `id_dest`.
- `id_hlt`  in  1  ID instruction is `HLT` (opcode 6'h3f).
- `ex_taken_branch`  in  1  EX resolved a taken BEQZ/BNEQZ this cycle.
- `stall`  out  1  hold PC and IF/ID, inject bubble into ID/EX.
- `flush`  out  1  squash IF/ID contents.
- `halted`  out  1  sticky: `HLT` issued; IF stops fetching.
- `drained`  out  1  `halted` and all scoreboard entries invalid.
- `stall_cnt`  out  `CNT_W`  saturating count of stall cycles.

## Operation
- Scoreboard: `SB_DEPTH` entries of {valid, addr[4:0]}. Every cycle entry[i] <= entry[i-1] for i ≥ 1. Entry[0] <= {id_wr && addr≠0, id_dest} when the ID instruction issues, otherwise it loads a bubble (valid = 0).
- Hazard: `hit` = `id_valid` and, for some valid entry with nonzero address, (`id_use_rs` and `id_rs` = addr) or (`id_use_rt` and `id_rt` = addr). R0 never creates a hazard.
- Issue = `id_valid` and not `hit` and not `flush` and not `halted`.
- `stall` = `hit` and not `flush` and not `halted`.
- `flush` = `ex_taken_branch`. Flush takes priority over stall and halt. The ID instruction is squashed and is not entered into the scoreboard. An `HLT` in ID during a flush is discarded and does not set `halted`.
- Halt: issuing an `HLT` sets `halted` on the next edge. While halted there is no further issue and `stall` = 0. `halted` clears only on reset.
- `stall_cnt` increments on each cycle with `stall` = 1 and saturates at all-ones.
- States: RUN (normal issue), HALTING (`halted` = 1, scoreboard not empty), DONE (`drained` = 1). RUN → HALTING on the edge after `HLT` issues. HALTING → DONE once the last valid entry shifts out. When `SB_DEPTH` = 1, RUN → DONE is possible directly.

## Timing
- `stall`, `flush` and `hit` are combinational from ID/EX inputs and scoreboard registers in the same cycle. There are no registered outputs except `halted`, `drained` and `stall_cnt`.
- Reset values: scoreboard all invalid, `halted` = 0, `drained` = 0, `stall_cnt` = 0. `stall` and `flush` follow their inputs, so they are 0 when all inputs are idle.
- Stall latency: a consumer at distance d ≤ `SB_DEPTH` behind its producer stalls for `SB_DEPTH` − d + 1 cycles. It issues on the cycle its producer leaves the last entry.
- Reset asserted mid-stall or mid-halt clears everything immediately (asynchronous). The first post-reset edge with an instruction in ID issues normally.
- Simultaneous hazard and taken branch: `flush` = 1, `stall` = 0, `stall_cnt` unchanged.

## Structure
- Shared package `mips32_pkg`:
  - opcode constants (ADD 6'h00 … HLT 6'h3f, BEQZ, BNEQZ, LW, SW),
  - `reg_addr_t` (5-bit),
  - scoreboard entry struct {valid, addr}.
- One natural sub-module: `mips32_scoreboard`, the parameterized shift register plus match logic, which outputs `hit`. The top level holds the issue, flush and halt sequencing and the counter.

## Test plan
- Program from `ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; ADD R4,R1,R2; ADD R5,R4,R3; HLT` with no dummy instructions, `SB_DEPTH` = 2 → `ADD R4` stalls 1 cycle and `ADD R5` stalls 2 cycles. Final R1..R5 = 10, 20, 25, 30, 55; `stall_cnt` = 3.
- `ADDI R0,R0,5` followed by `ADD R6,R0,R0` → no stall (R0 exempt); `stall_cnt` = 0.
- `ex_taken_branch` = 1 while ID holds a hazarding instruction → `flush` = 1, `stall` = 0, entry[0] invalid next cycle.
- `HLT` in ID coincident with `ex_taken_branch` → `halted` stays 0. A later unflushed `HLT` → `halted` = 1 next edge, and `drained` = 1 `SB_DEPTH` edges later.
- Assert `rst_n` = 0 mid-stall with a full scoreboard → all state clears asynchronously, `stall` = 0 with idle inputs, and `stall_cnt` = 0.
- `CNT_W` = 2 with 5 forced stall cycles → `stall_cnt` saturates at 3.
